// File: rtl/mont_pkg.sv
// -----------------------------------------------------------------------------
// mont_pkg
//   Shared definitions for the conventional-to-Montgomery domain converter.
//   Contents:
//     NBITS_DEFAULT : default operand width in bits
//     MSIZE_W       : default width of the m_size (bit-length) input
//     state_t       : controller states IDLE / DBL / DONE
// -----------------------------------------------------------------------------
package mont_pkg;

  localparam int NBITS_DEFAULT = 2048;
  localparam int MSIZE_W       = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/montgomery_to_conv_if.sv
// -----------------------------------------------------------------------------
// montgomery_to_conv_if
//   Bundles the operand/result signals of montgomery_to_conv.
//   Parameters: NBITS (operand width), MSIZE_W (m_size width).
//   Signals:
//     enable_p   master->slave  start pulse
//     a, m       master->slave  operand and modulus
//     m_size     master->slave  bit-length k of m
//     y          slave->master  result a*2^k mod m
//     done_irq_p slave->master  one-cycle completion pulse
//     busy       slave->master  operation in flight
//     err        slave->master  start-time input check failure
//
//   Handshake: a start is accepted on a rising clk edge where enable_p=1, the
//   slave is idle and done_irq_p is low; a, m and m_size are captured on that
//   edge only. busy rises on the accepting edge and falls on the edge that
//   raises done_irq_p for one cycle; y and err are valid from that edge and
//   held until the next completion. Pulses while busy are dropped, not queued.
// -----------------------------------------------------------------------------
interface montgomery_to_conv_if #(
  parameter int NBITS   = mont_pkg::NBITS_DEFAULT,
  parameter int MSIZE_W = mont_pkg::MSIZE_W
);
  logic               enable_p;
  logic [NBITS-1:0]   a;
  logic [NBITS-1:0]   m;
  logic [MSIZE_W-1:0] m_size;
  logic [NBITS-1:0]   y;
  logic               done_irq_p;
  logic               busy;
  logic               err;

  modport master (
    output enable_p, a, m, m_size,
    input  y, done_irq_p, busy, err
  );

  modport slave (
    input  enable_p, a, m, m_size,
    output y, done_irq_p, busy, err
  );
endinterface

// File: rtl/mont_dbl_mod.sv
// -----------------------------------------------------------------------------
// mont_dbl_mod
//   One combinational modular-doubling stage: r_nxt = (2r >= m) ? 2r - m : 2r.
//   Ports:
//     r     in   NBITS  current residue (r < m)
//     m     in   NBITS  modulus
//     r_nxt out  NBITS  doubled residue reduced once
// -----------------------------------------------------------------------------
module mont_dbl_mod #(
  parameter int NBITS = mont_pkg::NBITS_DEFAULT
) (
  input  logic [NBITS-1:0] r,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] r_nxt
);
  logic [NBITS:0]   dbl;
  logic [NBITS:0]   m_ext;
  logic [NBITS-1:0] diff;

  // Keep the carry out of the shift so the compare sees the true 2r.
  assign dbl   = {r, 1'b0};
  assign m_ext = {1'b0, m};
  // When 2r >= m the difference is below m < 2^NBITS, so the low NBITS bits
  // of the subtraction are exact and the borrow bit is never needed.
  assign diff  = dbl[NBITS-1:0] - m;
  assign r_nxt = (dbl >= m_ext) ? diff : dbl[NBITS-1:0];
endmodule

// File: rtl/montgomery_to_conv.sv
// -----------------------------------------------------------------------------
// montgomery_to_conv
//   Converts operand a into the Montgomery domain: y = a * 2^k mod m, with
//   k = m_size clamped to NBITS, by k serial modular doublings (one per cycle).
//   Latency from the accepting edge to done_irq_p is k+1 cycles.
//   Ports:
//     clk       in   single clock, rising edge
//     rst       in   synchronous active-high reset
//     bus       slave modport of montgomery_to_conv_if
//     state_dbg out  current controller state
//   Optional feature (macro MONT_TO_CONV_CHECK_EN): at the start edge an even
//   modulus or a >= m skips the doublings, returns y=0 and raises err until the
//   next accepted start or reset. Without the macro err is tied low.
// -----------------------------------------------------------------------------
module montgomery_to_conv #(
  parameter int NBITS   = mont_pkg::NBITS_DEFAULT,
  parameter int MSIZE_W = mont_pkg::MSIZE_W
) (
  input  logic             clk,
  input  logic             rst,
  montgomery_to_conv_if.slave bus,
  output mont_pkg::state_t state_dbg
);
  localparam logic [MSIZE_W-1:0] NBITS_K = MSIZE_W'(NBITS);
  localparam logic [MSIZE_W-1:0] ONE_K   = MSIZE_W'(1);

  mont_pkg::state_t   state_q, state_d;
  logic [NBITS-1:0]   r_q, m_q, y_q, r_dbl;
  logic [MSIZE_W-1:0] cnt_q, k_clamped;
  logic               done_q, busy_q;
  logic               start, in_bad;

  assign k_clamped = (bus.m_size > NBITS_K) ? NBITS_K : bus.m_size;

  // done_q is still high in the first IDLE cycle after a completion; starts
  // are refused there so the requester sees the result before re-arming.
  assign start = (state_q == mont_pkg::IDLE) && bus.enable_p && !done_q;

`ifdef MONT_TO_CONV_CHECK_EN
  logic err_q;
  assign in_bad  = !bus.m[0] || (bus.a >= bus.m);
  assign bus.err = err_q;

  always_ff @(posedge clk) begin
    if (rst)        err_q <= 1'b0;
    else if (start) err_q <= in_bad;
  end
`else
  assign in_bad  = 1'b0;
  assign bus.err = 1'b0;
`endif

  mont_dbl_mod #(.NBITS(NBITS)) u_dbl (
    .r     (r_q),
    .m     (m_q),
    .r_nxt (r_dbl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      mont_pkg::IDLE: begin
        if (start) begin
          if (in_bad || (k_clamped == '0)) state_d = mont_pkg::DONE;
          else                             state_d = mont_pkg::DBL;
        end
      end
      mont_pkg::DBL: begin
        if (cnt_q == ONE_K) state_d = mont_pkg::DONE;
      end
      mont_pkg::DONE: state_d = mont_pkg::IDLE;
      default:        state_d = mont_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= mont_pkg::IDLE;
      r_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        mont_pkg::IDLE: begin
          if (start) begin
            // A rejected start loads r=0 so DONE publishes y=0 unchanged.
            r_q    <= in_bad ? '0 : bus.a;
            m_q    <= bus.m;
            cnt_q  <= k_clamped;
            busy_q <= 1'b1;
          end
        end
        mont_pkg::DBL: begin
          r_q   <= r_dbl;
          cnt_q <= cnt_q - ONE_K;
        end
        mont_pkg::DONE: begin
          y_q    <= r_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.y          = y_q;
  assign bus.done_irq_p = done_q;
  assign bus.busy       = busy_q;
  assign state_dbg      = state_q;
endmodule

// File: tb/tb_montgomery_to_conv.sv
// -----------------------------------------------------------------------------
// tb_montgomery_to_conv
//   Bench for montgomery_to_conv at NBITS=16. Starts are issued by a driver
//   task that pushes the reference result into a queue; a negedge monitor pops
//   and compares on every done_irq_p, also checking latency, busy length and
//   that y holds between completions.
// -----------------------------------------------------------------------------
module tb_montgomery_to_conv;
  localparam int NB = 16;
  localparam int MW = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  montgomery_to_conv_if #(.NBITS(NB), .MSIZE_W(MW)) bus ();
  mont_pkg::state_t state_dbg;

  montgomery_to_conv #(.NBITS(NB), .MSIZE_W(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [NB:0] exp_q[$];   // {err, y}
  int          start_q[$];
  int          k_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic a*2^k mod m, with the optional input check.
  function automatic logic [NB:0] ref_model(input logic [NB-1:0] a, input logic [NB-1:0] m,
                                             input logic [MW-1:0] ms, output int k_eff);
    int k;
    longint unsigned p;
    k = (int'(ms) > NB) ? NB : int'(ms);
`ifdef MONT_TO_CONV_CHECK_EN
    if (m[0] == 1'b0 || a >= m) begin
      k_eff = 0;
      return {1'b1, {NB{1'b0}}};
    end
`endif
    k_eff = k;
    p = (longint'(a) << k) % longint'(m);
    return {1'b0, p[NB-1:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic run(input logic [NB-1:0] a, input logic [NB-1:0] m,
                     input logic [MW-1:0] ms, input bit expect_accept);
    logic [NB:0] e;
    int k_eff;
    @(negedge clk);
    bus.a        = a;
    bus.m        = m;
    bus.m_size   = ms;
    bus.enable_p = 1'b1;
    @(posedge clk);
    #1;
    if (expect_accept) begin
      e = ref_model(a, m, ms, k_eff);
      exp_q.push_back(e);
      start_q.push_back(cyc);
      k_q.push_back(k_eff);
    end
    @(negedge clk);
    bus.enable_p = 1'b0;
    // Operand changes after the start edge must not reach the result.
    bus.a        = NB'($urandom);
    bus.m        = NB'($urandom);
    bus.m_size   = MW'($urandom_range(0, 40));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wait_idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done_irq_p && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wait_done_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- monitor ----------------
  int          busy_cnt  = 0;
  bit          rst_seen  = 1'b1;
  logic [NB-1:0] last_y  = '0;

  always @(negedge clk) begin
    logic [NB:0] e;
    int s, k;
    if (rst) begin
      busy_cnt = 0;
      rst_seen = 1'b1;
    end else begin
      if (rst_seen) begin
        last_y   = bus.y;
        rst_seen = 1'b0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done_irq_p) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          s = start_q.pop_front();
          k = k_q.pop_front();
          check("y",       32'(bus.y),   32'(e[NB-1:0]));
          check("err",     32'(bus.err), 32'(e[NB]));
          check("latency", 32'(cyc - s), 32'(k + 1));
          check("busy_len", 32'(busy_cnt), 32'(k + 1));
        end
        busy_cnt = 0;
        last_y   = bus.y;
      end else begin
        check("y_hold", 32'(bus.y), 32'(last_y));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NB-1:0] rm, ra;
    bus.enable_p = 1'b0;
    bus.a        = '0;
    bus.m        = '0;
    bus.m_size   = '0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_y",     32'(bus.y),          32'd0);
    check("rst_busy",  32'(bus.busy),       32'd0);
    check("rst_done",  32'(bus.done_irq_p), 32'd0);
    check("rst_err",   32'(bus.err),        32'd0);
    check("rst_state", 32'(state_dbg),      32'(mont_pkg::IDLE));
    rst = 1'b0;

    // Directed cases
    run(16'd5,   16'd13,  12'd4, 1'b1); wait_idle();
    run(16'd250, 16'd251, 12'd8, 1'b1); wait_idle();
    run(16'd0,   16'd251, 12'd8, 1'b1); wait_idle();
    run(16'd7,   16'd13,  12'd0, 1'b1); wait_idle();
    run(16'd1234, 16'd65521, 12'd20, 1'b1); wait_idle();

    // Second pulse during a k=8 run is dropped
    run(16'd100, 16'd251, 12'd8, 1'b1);
    run(16'd3,   16'd7,   12'd2, 1'b0);
    wait_idle();

    // Pulse in the done_irq_p cycle is dropped
    run(16'd9, 16'd13, 12'd3, 1'b1);
    wait_done();
    bus.a = 16'd1; bus.m = 16'd13; bus.m_size = 12'd2; bus.enable_p = 1'b1;
    @(negedge clk);
    bus.enable_p = 1'b0;
    repeat (6) @(negedge clk);
    check("done_cycle_start_busy", 32'(bus.busy), 32'd0);
    check("done_cycle_start_q",    32'(exp_q.size()), 32'd0);

    // Reset in the middle of a k=8 run aborts it
    run(16'd77, 16'd251, 12'd8, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_y",    32'(bus.y),     32'd0);
    check("abort_busy", 32'(bus.busy),  32'd0);
    check("abort_err",  32'(bus.err),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    start_q.delete();
    k_q.delete();
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(bus.busy), 32'd0);
    run(16'd5, 16'd13, 12'd4, 1'b1); wait_idle();

`ifdef MONT_TO_CONV_CHECK_EN
    run(16'd5,  16'd12, 12'd4, 1'b1); wait_idle();
    run(16'd20, 16'd13, 12'd4, 1'b1); wait_idle();
    run(16'd6,  16'd13, 12'd4, 1'b1); wait_idle();
`endif

    // Random operands: odd modulus, a < m, k across and beyond NBITS
    for (int i = 0; i < 25; i++) begin
      rm = NB'($urandom_range(3, 65535)) | 16'd1;
      ra = NB'($urandom % 32'(rm));
      run(ra, rm, MW'($urandom_range(0, 20)), 1'b1);
      wait_idle();
    end

    repeat (4) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/montgomery_to_conv.md
MONTGOMERY_TO_CONV -- requirements
Module: montgomery_to_conv

Interface
REQ-001 SHALL have parameter NBITS, default 2048: operand width in bits.
REQ-002 SHALL have parameter MSIZE_W, default 12: width of m_size.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable_p  input  1  start pulse; sampled only in IDLE.
REQ-006 a  input  NBITS  conventional-domain operand; precondition a < m.
REQ-007 m  input  NBITS  modulus; precondition m odd.
REQ-008 m_size  input  MSIZE_W  bit-length k of m; R = 2^k.
REQ-009 y  output  NBITS  registered result a*R mod m; held until next completion.
REQ-010 done_irq_p  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high from the start edge until the done edge.
REQ-012 err  output  1  input-check failure flag; see Configuration.

Function
REQ-013 SHALL compute y = (a * 2^k) mod m by k iterations of r <- 2r, then subtract m if 2r >= m.
REQ-014 Doubling SHALL use NBITS+1-bit intermediate width; no carry SHALL be lost.
REQ-015 FSM states SHALL be IDLE, DBL and DONE.
REQ-016 IDLE with enable_p=1: r<=a, cnt<=k; go to DBL, or to DONE if k==0; busy<=1.
REQ-017 DBL: each cycle SHALL perform one iteration and cnt<=cnt-1; when cnt==1, go to DONE.
REQ-018 DONE: y<=r, done_irq_p<=1 for exactly one cycle, busy<=0; go to IDLE.
REQ-019 Latency SHALL be k+1 cycles from the enable_p sampling edge to done_irq_p high.
REQ-020 enable_p while busy SHALL be ignored; no queuing.
REQ-021 enable_p in the same cycle as done_irq_p SHALL be ignored; a new start is accepted from the next cycle.
REQ-022 a, m and m_size SHALL be sampled only at the start edge; changes during busy SHALL have no effect.
REQ-023 m_size > NBITS SHALL be clamped to NBITS.
REQ-024 k==0 SHALL yield y=a.
REQ-025 y SHALL NOT change except at the DONE edge or on reset.

Reset
REQ-026 rst=1 at any edge SHALL force: IDLE, y=0, done_irq_p=0, busy=0, err=0, r=0, cnt=0.
REQ-027 Reset mid-operation SHALL abort the operation; no done_irq_p SHALL follow.
REQ-028 rst SHALL take priority over enable_p in the same cycle.

Configuration
REQ-029 Macro MONT_TO_CONV_CHECK_EN SHALL control start-time input checking.
REQ-030 With MONT_TO_CONV_CHECK_EN defined: at the start edge, if m[0]==0 or a >= m, go directly to DONE with y<=0 and err<=1.
REQ-031 With the macro defined: err SHALL remain set until the next accepted start or reset; a valid start SHALL clear it.
REQ-032 Without the macro: err SHALL be tied to 0 and no comparison logic SHALL be synthesized.

Structure
REQ-033 Shared package mont_pkg SHALL hold the FSM state typedef (IDLE/DBL/DONE), MSIZE_W and the default NBITS constant.
REQ-034 Sub-module mont_dbl_mod SHALL implement one combinational stage: r_nxt = (2r >= m) ? 2r - m : 2r.
REQ-035 The top level SHALL hold the FSM, counter, operand registers and output registers.

Verification (NBITS=16)
REQ-036 a=5, m=13, k=4, pulse enable_p -> done_irq_p 5 cycles later; y=2; busy high for 5 cycles.
REQ-037 a=250, m=251, k=8 -> y=246 after 9 cycles; a=0 -> y=0.
REQ-038 k=0, a=7 -> y=7 and done_irq_p 1 cycle after start; k=20 -> behaves as k=16.
REQ-039 Second enable_p 2 cycles into a k=8 run -> ignored; exactly one done_irq_p; y unchanged by the second pulse's operands.
REQ-040 rst at cycle 3 of a k=8 run -> y=0, busy=0; no done_irq_p; a fresh start then completes correctly.
REQ-041 With MONT_TO_CONV_CHECK_EN: m=12 or a=20, m=13 -> done_irq_p 1 cycle after start, y=0, err=1; next valid run clears err.
